mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares one single-ported backing memory between the instruction-fetch miss path and the data-cache miss/store path of the pipelined core. It accepts one request at a time from either requester and grants by fixed priority (data first) with a starvation guard for fetch. It drives a req/ack memory handshake and returns read data with a one-cycle done pulse. It generates the pipeline stall used alongside the hazard unit's StallF/StallD.

## Interface
- STARVE_LIMIT, 4, max consecutive data grants while a fetch request waits; must be ≥1
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- i_req  in  1  fetch request; held high until i_done seen
- i_addr  in  ADDR_WIDTH  fetch address; stable while i_req high
- i_rdata  out  DATA_WIDTH  fetch read data; valid when i_done=1
- i_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held high until d_done seen
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data; valid when d_done=1
- d_done  out  1  one-cycle data completion pulse
- mem_req  out  1  backing-memory request
- mem_we  out  1  backing-memory write enable
- mem_addr  out  ADDR_WIDTH  backing-memory address
- mem_wdata  out  DATA_WIDTH  backing-memory write data
- mem_rdata  in  DATA_WIDTH  backing-memory read data; valid with mem_ack
- mem_ack  in  1  single-cycle completion from memory
- stall  out  1  combinational: (i_req & ~i_done) | (d_req & ~d_done)

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if d_req and not (i_req and streak==STARVE_LIMIT) → BUSY_D; else if i_req → BUSY_I; else stay.
- On grant, latch addr/we/wdata into mem_addr/mem_we/mem_wdata (fetch grant: mem_we=0, mem_wdata unchanged) and set mem_req=1.
- Data grant: streak increments (saturating at STARVE_LIMIT) if i_req=1, else clears to 0. Fetch grant: streak clears to 0. Streak width clog2(STARVE_LIMIT+1).
- BUSY_x: mem_req, mem_addr, mem_we, mem_wdata stable until mem_ack. On mem_ack: capture mem_rdata into i_rdata or d_rdata (stores capture too; value unspecified to requester), clear mem_req, → RESP.
- RESP: assert i_done or d_done (matching owner) for exactly one cycle, → IDLE. Requesters drop req at the edge ending RESP, so IDLE never regrants a completed request.
- mem_ack in IDLE or RESP is ignored.
- i_rdata/d_rdata hold last captured value until the next capture.

## Timing
- Reset (rst=1 at an edge): state IDLE, streak 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_done=0, d_done=0, i_rdata=0, d_rdata=0. Applies mid-transaction: in-flight access abandoned, mem_req low the cycle after reset; late mem_ack ignored.
- Request sampled at edge E0 → mem_req=1 from cycle E0+1. mem_ack may arrive in first BUSY cycle.
- Minimum latency: req at cycle 0, ack in cycle 1, done in cycle 2. Generally done = cycle after ack.
- Back-to-back: one idle cycle between RESP and the next grant; a pending other-port request is granted at the end of that IDLE cycle.
- Simultaneous i_req and d_req in IDLE: data wins unless streak==STARVE_LIMIT.
- stall is combinational and falls in the done cycle.

## Test plan
- Reset: hold rst 2 cycles with i_req=d_req=1 → all registered outputs 0, mem_req=0; after release, d granted first.
- Fetch read: i_req=1, i_addr=0x00000100, mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF → mem_we=0, mem_addr=0x100, i_done one cycle after ack, i_rdata=0xDEADBEEF, stall low in i_done cycle.
- Store: d_req=1, d_we=1, d_addr=0x00010000, d_wdata=0x12345678, immediate ack → mem_we=1, mem_wdata=0x12345678, d_done in cycle 2, d_done width exactly 1 cycle.
- Simultaneous: i_req and d_req rise together → d served first (mem_addr=d_addr), one IDLE cycle after d_done, then fetch granted.
- Starvation (STARVE_LIMIT=2): i_req held, d_req reasserted right after each d_done → two data grants, third grant is fetch, then streak 0 and data wins again.
- Reset mid-BUSY_D: rst during wait → mem_req=0 next cycle, no d_done, later mem_ack ignored, new i_req served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported backing memory between the fetch miss path and the
// data miss/store path. One transaction at a time, data has priority, and a
// streak counter guarantees fetch a grant after STARVE_LIMIT consecutive data
// grants while it waits.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,  // must be >= 1
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  // backing memory
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  // pipeline stall
  output logic                  stall
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t                state_q,     state_d;
  logic [SW-1:0]         streak_q,    streak_d;
  logic                  mem_req_q,   mem_req_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  i_done_q,    i_done_d;
  logic                  d_done_q,    d_done_d;
  logic [DATA_WIDTH-1:0] i_rdata_q,   i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;

  logic fetch_starved;
  assign fetch_starved = i_req && (streak_q == LIMIT);

  // Next-state: arbitration in IDLE, wait for ack in BUSY, one-cycle done in RESP.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req && !fetch_starved) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Only a waiting fetch makes data grants count towards starvation.
          if (i_req) streak_d = (streak_q == LIMIT) ? LIMIT : streak_q + SW'(1);
          else       streak_d = '0;
        end else if (i_req) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          streak_d   = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          i_rdata_d = mem_rdata;
          i_done_d  = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          d_rdata_d = mem_rdata;
          d_done_d  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    // NOTE: the read-data holding registers are reset too, since requesters may observe them at any time.
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Stall drops combinationally in the done cycle of the pending requester.
  assign stall = (i_req & ~i_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with STARVE_LIMIT=2: reset, fetch read,
// store, simultaneous requests, starvation guard and reset mid-transaction.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, d_done, mem_req, mem_we, stall;

  int n_checks = 0;
  int n_fail   = 0;
  int waited;

  mem_port_arbiter #(.STARVE_LIMIT(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant (bounded), checks the latched command, holds for `delay`
  // BUSY cycles, acks, and returns at the negedge of the RESP cycle.
  task automatic serve(input string tag, input int delay, input logic [31:0] rdata,
                       input logic exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, output int wcnt);
    wcnt = 0;
    @(negedge clk);
    while (!mem_req && wcnt < 10) begin
      wcnt++;
      @(negedge clk);
    end
    if (!mem_req) begin
      check({tag, "_grant_timeout"}, mem_req, 1'b1);
      return;
    end
    check({tag, "_we"},    mem_we,    exp_we);
    check({tag, "_addr"},  mem_addr,  exp_addr);
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    repeat (delay) begin
      @(negedge clk);
      check({tag, "_hold"}, {mem_req, mem_we, mem_addr}, {1'b1, exp_we, exp_addr});
      check({tag, "_early_done"}, {i_done, d_done}, 2'b00);
    end
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic edge_drive();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_00A0; d_wdata = 32'h0;

    // Reset held two edges with both requests high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_dones", {i_done, d_done}, 2'b00);
    check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    rst = 1'b0;

    // Data wins at the first edge after release; fetch follows after one IDLE cycle.
    serve("rst_ld", 0, 32'h0000_0055, 1'b0, 32'h0000_00A0, 32'h0, waited);
    check("rst_ld_first_edge", waited, 0);
    check("rst_ld_done", {i_done, d_done}, 2'b01);
    check("rst_ld_rdata", d_rdata, 32'h0000_0055);
    check("rst_ld_stall", stall, 1'b1);
    edge_drive(); d_req = 1'b0;
    @(negedge clk);
    check("b2b_idle_gap", {mem_req, d_done}, 2'b00);
    serve("fetch", 3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 32'h0, waited);
    check("fetch_grant_after_idle", waited, 0);
    check("fetch_done", {i_done, d_done}, 2'b10);
    check("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
    check("fetch_stall_low", stall, 1'b0);
    check("fetch_mem_req_low", mem_req, 1'b0);
    edge_drive(); i_req = 1'b0;
    @(negedge clk);
    check("fetch_done_width", i_done, 1'b0);

    // Store with immediate ack: request in cycle 0, done in cycle 2.
    edge_drive();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0001_0000; d_wdata = 32'h1234_5678;
    serve("store", 0, 32'h0000_0077, 1'b1, 32'h0001_0000, 32'h1234_5678, waited);
    check("store_latency", waited, 1);
    check("store_done", {i_done, d_done}, 2'b01);
    check("store_stall_low", stall, 1'b0);
    edge_drive(); d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("store_done_width", d_done, 1'b0);

    // Fetch after store: mem_we cleared, mem_wdata keeps the store data.
    edge_drive();
    i_req = 1'b1; i_addr = 32'h0000_2000;
    serve("fetch2", 1, 32'h0BAD_F00D, 1'b0, 32'h0000_2000, 32'h1234_5678, waited);
    check("fetch2_done", i_done, 1'b1);
    check("fetch2_rdata", i_rdata, 32'h0BAD_F00D);
    check("d_rdata_held", d_rdata, 32'h0000_0077);
    edge_drive(); i_req = 1'b0;

    // Starvation: two data grants, then fetch, then data wins again.
    edge_drive();
    i_req = 1'b1; i_addr = 32'h0000_0300;
    d_req = 1'b1; d_addr = 32'h0000_0200;
    serve("starve_d1", 0, 32'h1, 1'b0, 32'h0000_0200, 32'h1234_5678, waited);
    check("starve_d1_done", {i_done, d_done}, 2'b01);
    edge_drive();
    serve("starve_d2", 0, 32'h2, 1'b0, 32'h0000_0200, 32'h1234_5678, waited);
    check("starve_d2_gap", waited, 1);
    check("starve_d2_done", {i_done, d_done}, 2'b01);
    edge_drive();
    serve("starve_f", 0, 32'h3, 1'b0, 32'h0000_0300, 32'h1234_5678, waited);
    check("starve_f_done", {i_done, d_done}, 2'b10);
    check("starve_f_rdata", i_rdata, 32'h3);
    check("starve_f_stall", stall, 1'b1);
    edge_drive();
    serve("starve_d3", 0, 32'h4, 1'b0, 32'h0000_0200, 32'h1234_5678, waited);
    check("starve_d3_done", {i_done, d_done}, 2'b01);
    check("starve_d3_rdata", d_rdata, 32'h4);
    edge_drive(); i_req = 1'b0; d_req = 1'b0;

    // Reset while BUSY_D waits for an ack; the late ack must be ignored.
    edge_drive();
    d_req = 1'b1; d_addr = 32'h0000_0400;
    @(negedge clk);
    @(negedge clk);
    check("midrst_granted", {mem_req, mem_addr}, {1'b1, 32'h0000_0400});
    edge_drive(); rst = 1'b1;
    edge_drive(); rst = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
    @(negedge clk);
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_no_done", d_done, 1'b0);
    check("midrst_addr", mem_addr, 32'h0);
    edge_drive(); mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check("late_ack_ignored", {mem_req, d_done, i_done}, 3'b000);
    check("late_ack_rdata", d_rdata, 32'h0);
    edge_drive();
    i_req = 1'b1; i_addr = 32'h0000_0500;
    serve("post_rst_fetch", 1, 32'hCAFE_F00D, 1'b0, 32'h0000_0500, 32'h0, waited);
    check("post_rst_fetch_done", {i_done, d_done}, 2'b10);
    check("post_rst_fetch_rdata", i_rdata, 32'hCAFE_F00D);
    edge_drive(); i_req = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
